// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP   = ADDR_W'(4);
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a valid bit plus the fetched payload.
// Controls: clear (drop valid) wins over load (capture d); otherwise hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  // Valid bit: clear beats load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload only changes on a load; a clear leaves the stale word in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};
    end else if (load && !clear) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, next-PC selection and the
// IF/ID register feeding decode over a valid/ready handshake.
// Optional feature macro: FETCH_BOUND_CHECK_EN (sticky out-of-range fault).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                MEM_BYTES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               flush,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr,
  output logic               fault
);

  if ((MEM_BYTES % 4) != 0 || MEM_BYTES < 4 || RESET_PC[1:0] != 2'b00) begin : g_bad_params
    $error("fetch_stage: MEM_BYTES must be a multiple of 4 and RESET_PC 4-byte aligned");
  end

  logic [ADDR_W-1:0] pc, pc_d;
  logic              advance;
  logic              load, clear;
  if_id_t            slot_d, slot_q;
  logic [1:0]        unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign advance   = !if_valid || id_ready;
  assign imem_addr = pc;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);
  logic fault_q, fault_d;
  logic oob;

  assign oob   = pc > LAST_PC;
  assign fault = fault_q;

  // Sticky fault flag; only reset or a redirect clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  assign fault = 1'b0;
`endif

  // Next-PC and slot control: redirect > flush > fault hold > advance > stall.
  always_comb begin
    pc_d  = pc;
    load  = 1'b0;
    clear = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
    fault_d = fault_q;
`endif
    if (redirect_valid) begin
      pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
      clear = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
      fault_d = 1'b0;
`endif
    end else if (flush) begin
      clear = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
    end else if (fault_q) begin
      // frozen until a redirect
    end else if (advance && oob) begin
      fault_d = 1'b1;
      clear   = 1'b1;
`endif
    end else if (advance) begin
      load = 1'b1;
      pc_d = pc + PC_STEP;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_d;
  end

  assign slot_d = '{pc: pc, pc_plus4: pc + PC_STEP, instr: imem_instr};

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .clear (clear),
    .d     (slot_d),
    .valid (if_valid),
    .q     (slot_q)
  );

  assign if_pc       = slot_q.pc;
  assign if_pc_plus4 = slot_q.pc_plus4;
  assign if_instr    = slot_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected fetches are queued when the
// PC is (re)started and compared as decode accepts each word.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:63];
  logic [31:0] sb_q [$];

  fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return ~a ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare each word as decode takes it.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !redirect_valid && !flush) begin
      if (sb_q.size() == 0) begin
        chk("sb_pending", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_pc_plus4", if_pc_plus4, e + 32'd4);
        chk("sb_instr", if_instr, mem_word(e));
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'(i + 1), 24'($urandom)};
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    flush = 1'b0;
    id_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc_plus4", if_pc_plus4, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    sb_restart(32'h0, 40);
    step();
    rst_n = 1'b1;
    step();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, 32'd0);
    step();
    chk("seq_pc4", if_pc, 32'd4);

    // stall with if_pc = 4
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", if_pc, 32'd4);
      chk("stall_instr", if_instr, mem[1]);
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_valid", 32'(if_valid), 32'd1);
    end
    id_ready = 1'b1;
    step();
    chk("release_pc", if_pc, 32'd8);

    // redirect to misaligned target while decode stalls
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    sb_restart(32'h40, 8);
    step();
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, mem[16]);

    // get pc to 12 for the flush test
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    sb_restart(32'h0, 8);
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    step();
    step();
    chk("pre_flush_addr", imem_addr, 32'd12);
    flush = 1'b1;
    id_ready = 1'b0;
    step();
    chk("flush_valid", 32'(if_valid), 32'd0);
    chk("flush_addr", imem_addr, 32'd12);
    flush = 1'b0;
    id_ready = 1'b1;
    sb_restart(32'd12, 8);
    step();
    chk("flush_pc", if_pc, 32'd12);

    // flush and redirect together: redirect wins
    flush = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    id_ready = 1'b0;
    sb_restart(32'h80, 8);
    step();
    chk("fr_addr", imem_addr, 32'h80);
    chk("fr_valid", 32'(if_valid), 32'd0);
    flush = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    chk("fr_pc", if_pc, 32'h80);

`ifdef FETCH_BOUND_CHECK_EN
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hF8;
    sb_restart(32'hF8, 2);
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    step();
    chk("last_pc", if_pc, 32'hFC);
    step();
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_valid", 32'(if_valid), 32'd0);
    chk("oob_addr", imem_addr, 32'h100);
    step();
    chk("oob_hold_fault", 32'(fault), 32'd1);
    chk("oob_hold_addr", imem_addr, 32'h100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    sb_restart(32'h0, 8);
    step();
    chk("clr_fault", 32'(fault), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("resume_pc", if_pc, 32'h0);
    chk("resume_valid", 32'(if_valid), 32'd1);
`else
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_restart(32'hFFFF_FFFC, 8);
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    step();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", if_pc_plus4, 32'h0);
    chk("wrap_instr", if_instr, ~32'hFFFF_FFFC ^ 32'h5A5A_0000);
    chk("wrap_fault", 32'(fault), 32'd0);
    step();
    chk("wrap_next_pc", if_pc, 32'h0);
`endif

    // reset asserted mid-stall acts immediately
    id_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_pc_plus4", if_pc_plus4, 32'd0);
    chk("arst_instr", if_instr, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for the single-issue datapath. Holds the program counter, drives the byte address into the instruction memory (big-endian, byte-addressed, 4 bytes per instruction), and captures each returned 32-bit word into the IF/ID pipeline register. Downstream handshake with decode uses valid/ready. Upstream control can redirect or flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- MEM_BYTES, 256, instruction memory size in bytes; must be a multiple of 4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- imem_addr  output  32  byte address to instruction memory; equals the current PC (combinational from the PC register).
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  load a new PC this cycle (branch or jump).
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- flush  input  1  invalidate IF/ID contents without changing the PC.
- id_ready  input  1  decode accepts if_* this cycle.
- if_valid  output  1  IF/ID holds a valid instruction.
- if_pc  output  32  PC of the held instruction.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- if_instr  output  32  held instruction word.
- fault  output  1  sticky out-of-range fetch flag (see Configuration).

## Operation
- advance = !if_valid || id_ready. The output slot is empty or is being consumed.
- Per-cycle priority is redirect_valid, then flush, then fault hold, then advance, then stall.
- redirect_valid:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - if_valid <= 0; wrong-path word discarded.
  - fault <= 0.
  - Applied regardless of id_ready or flush.
- flush without redirect: if_valid <= 0. PC holds, so the word at the current PC is captured on the next advance.
- fault set: PC, if_valid and if_* hold; no capture.
- advance: if_instr <= imem_instr, if_pc <= pc, if_pc_plus4 <= pc+4, if_valid <= 1, pc <= pc+4.
- stall (if_valid && !id_ready): all registers hold. if_* stays stable until accepted.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 0.
- The imem_instr value is consumed only on a capture edge, so content is irrelevant in other cycles.

## Timing
- Reset values (asynchronous, on rst_n low):
  - pc = RESET_PC.
  - if_valid = 0, if_pc = 0, if_pc_plus4 = 0, if_instr = 0, fault = 0.
- First capture happens on the first rising edge after rst_n deasserts. if_valid = 1 from that edge.
- Fetch latency: the word at PC p appears on if_instr one cycle after imem_addr = p.
- Redirect latency: imem_addr = target one cycle after redirect_valid, and the target word is on if_* two cycles after.
- Throughput is one instruction per cycle while id_ready = 1.
- Reset asserted mid-stall or mid-redirect overrides everything and returns all state to reset values.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - On an advance with pc > MEM_BYTES-4, no capture occurs.
  - fault <= 1 (sticky) and if_valid <= 0.
  - Cleared only by reset or by a redirect.
  - If that redirect is itself out of range, fault sets again at the next advance.
- FETCH_BOUND_CHECK_EN undefined:
  - fault is tied to 0.
  - Out-of-range addresses are driven unchanged, and the captured word is whatever memory returns.

## Structure
- Shared package fetch_pkg:
  - PC_STEP = 4.
  - INSTR_W = 32, ADDR_W = 32.
  - NOP_INSTR = 32'h0000_0000.
  - Typedef if_id_t { pc, pc_plus4, instr }.
- One sub-module, if_id_reg:
  - Holds the valid bit and payload.
  - Provides load, hold and clear controls.
  - Async active-low reset.
- fetch_stage contains the PC register, next-PC selection, bound check and the instance of if_id_reg.

## Test plan
- Reset with RESET_PC = 0, id_ready = 1, and memory preloaded with words W0..W3 at 0,4,8,12 -> over 4 cycles, if_pc = 0,4,8,12 and if_instr = W0..W3, with if_valid = 1 from the first edge.
- id_ready = 0 for 3 cycles while if_pc = 4 -> if_pc, if_instr and imem_addr stay at 4/W1/8; on release, the next edge shows if_pc = 8.
- redirect_valid with redirect_pc = 32'h0000_0043 while id_ready = 0:
  - Next cycle: if_valid = 0 and imem_addr = 32'h40.
  - Following cycle: if_pc = 32'h40.
- flush alone with pc = 12 -> if_valid = 0 and pc stays 12; the next cycle captures if_pc = 12. With flush and redirect together, redirect wins.
- With FETCH_BOUND_CHECK_EN and MEM_BYTES = 256:
  - Run sequentially to pc = 256 -> fault = 1, if_valid = 0 and pc holds at 256.
  - Redirect to 0 -> fault = 0, and fetch resumes at 0.
- Redirect to 32'hFFFF_FFFC without the macro -> if_pc = FFFF_FFFC with if_pc_plus4 = 0, and the next if_pc = 0.
- Assert rst_n low mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.
